alarm_ctrl: RTL and testbench

- Alarm stage downstream of the 24-hour time counters; consumes current BCD time digits plus the 1 Hz enable and 2 Hz blink signal.
- Holds a user-set alarm time (HH:MM), detects the match, and drives a beeper with snooze and auto-stop.
- Exports alarm digits and blink enables so the top level can mux them onto the 7-segment decoders while the alarm is being set.

---
 rtl/alarm_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm stage for the 24-hour clock.
// Holds a user-set HH:MM alarm, detects the match against the running time, and rings the
// beeper. While ringing, the alarm supports snooze and stops by itself after a set time.
// It also exports the alarm digits and blink enables so the top level can show the alarm while
// it is being set.
//
// Ports:
//   CLK, RST           clock; synchronous active-low reset
//   en1hz, sig2hz      1 Hz one-cycle tick; 2 Hz square wave for blink and beep
//   hour10..sec1       current time, BCD
//   almset             enter set mode / advance field
//   almadj             increment field / snooze
//   almoff             toggle armed / stop ring
//   alm_hour10..min1   alarm time, BCD
//   almdisp            high while the alarm is being set
//   houron, minon      digit display enables (blink on the field under edit)
//   armed, buzz        armed indicator, beeper drive
//
// Optional feature macro: ALARM_SNOOZE_LIMIT_EN limits snoozes to SNOOZE_MAX per alarm event.
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned SNOOZE_MAX = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en1hz,
  input  logic       sig2hz,
  input  logic [1:0] hour10,
  input  logic [3:0] hour1,
  input  logic [2:0] min10,
  input  logic [3:0] min1,
  input  logic [2:0] sec10,
  input  logic [3:0] sec1,
  input  logic       almset,
  input  logic       almadj,
  input  logic       almoff,
  output logic [1:0] alm_hour10,
  output logic [3:0] alm_hour1,
  output logic [2:0] alm_min10,
  output logic [3:0] alm_min1,
  output logic       almdisp,
  output logic       houron,
  output logic       minon,
  output logic       armed,
  output logic       buzz
);

  localparam logic [8:0] RingLim   = RING_SEC[8:0];
  localparam logic [8:0] SnoozeLim = SNOOZE_SEC[8:0];

  typedef enum logic [2:0] {StNormal, StSetHour, StSetMin, StRing, StSnooze} state_e;

  state_e     state_q, state_d;
  logic [1:0] ah10_q, ah10_d;
  logic [3:0] ah1_q, ah1_d;
  logic [2:0] am10_q, am10_d;
  logic [3:0] am1_q, am1_d;
  logic       armed_q, armed_d;
  logic       match_q, match_d;
  logic [8:0] sec_cnt_q, sec_cnt_d;
  logic [8:0] sec_cnt_inc;
  logic       match_rise;
  logic       snooze_ok;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam logic [7:0] SnzMax = SNOOZE_MAX[7:0];
  logic [7:0] snz_cnt_q, snz_cnt_d;
`else
  logic unused_snooze_max;
  assign unused_snooze_max = ^SNOOZE_MAX;
`endif

  always_comb begin
    match_d     = ({hour10, hour1, min10, min1} == {ah10_q, ah1_q, am10_q, am1_q}) &&
                  (sec10 == 3'd0) && (sec1 == 4'd0);
    // Only the first cycle of a match may trigger, so stopping during :00 does not re-ring.
    match_rise  = match_d & ~match_q;
    sec_cnt_inc = sec_cnt_q + 9'd1;
    state_d     = state_q;
    ah10_d      = ah10_q;
    ah1_d       = ah1_q;
    am10_d      = am10_q;
    am1_d       = am1_q;
    armed_d     = armed_q;
    sec_cnt_d   = sec_cnt_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
    snz_cnt_d   = snz_cnt_q;
    snooze_ok   = (snz_cnt_q != SnzMax);
`else
    snooze_ok   = 1'b1;
`endif

    unique case (state_q)
      StNormal: begin
        if (almoff) begin
          armed_d = ~armed_q;
        end else if (almset) begin
          state_d = StSetHour;
        end else if (armed_q && match_rise) begin
          state_d = StRing;
        end
      end
      StSetHour: begin
        if (almset) begin
          state_d = StSetMin;
        end else if (almadj) begin
          if (ah10_q == 2'd2 && ah1_q == 4'd3) begin
            ah10_d = 2'd0;
            ah1_d  = 4'd0;
          end else if (ah1_q == 4'd9) begin
            ah10_d = ah10_q + 2'd1;
            ah1_d  = 4'd0;
          end else begin
            ah1_d = ah1_q + 4'd1;
          end
        end
      end
      StSetMin: begin
        if (almset) begin
          state_d = StNormal;
          armed_d = 1'b1;
        end else if (almadj) begin
          if (am1_q == 4'd9) begin
            am1_d  = 4'd0;
            am10_d = (am10_q == 3'd5) ? 3'd0 : am10_q + 3'd1;
          end else begin
            am1_d = am1_q + 4'd1;
          end
        end
      end
      StRing: begin
        if (almoff) begin
          state_d = StNormal;
        end else if (almadj && snooze_ok) begin
          state_d = StSnooze;
        end else if (en1hz) begin
          if (sec_cnt_inc == RingLim) state_d = StNormal;
          else                        sec_cnt_d = sec_cnt_inc;
        end
      end
      StSnooze: begin
        if (almoff) begin
          state_d = StNormal;
        end else if (en1hz) begin
          if (sec_cnt_inc == SnoozeLim) state_d = StRing;
          else                          sec_cnt_d = sec_cnt_inc;
        end
      end
      default: state_d = StNormal;
    endcase

    // One shared seconds counter: every state change restarts it.
    if (state_d != state_q) sec_cnt_d = '0;

`ifdef ALARM_SNOOZE_LIMIT_EN
    if (state_q == StRing && state_d == StSnooze) snz_cnt_d = snz_cnt_q + 8'd1;
    if (state_q != StNormal && state_d == StNormal) snz_cnt_d = '0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StNormal;
      ah10_q    <= '0;
      ah1_q     <= '0;
      am10_q    <= '0;
      am1_q     <= '0;
      armed_q   <= 1'b0;
      match_q   <= 1'b0;
      sec_cnt_q <= '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ah10_q    <= ah10_d;
      ah1_q     <= ah1_d;
      am10_q    <= am10_d;
      am1_q     <= am1_d;
      armed_q   <= armed_d;
      match_q   <= match_d;
      sec_cnt_q <= sec_cnt_d;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_cnt_q <= snz_cnt_d;
`endif
    end
  end

  assign alm_hour10 = ah10_q;
  assign alm_hour1  = ah1_q;
  assign alm_min10  = am10_q;
  assign alm_min1   = am1_q;
  assign armed      = armed_q;
  assign almdisp    = (state_q == StSetHour) || (state_q == StSetMin);
  assign houron     = (state_q != StSetHour) || sig2hz;
  assign minon      = (state_q != StSetMin) || sig2hz;
  assign buzz       = (state_q == StRing) && sig2hz;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed walk through the alarm use cases, then
// randomized button/time traffic, all compared every cycle against a behavioural model.
module tb_alarm_ctrl;

  localparam int RingSec   = 60;
  localparam int SnoozeSec = 300;
  localparam int SnoozeMax = 3;

  // Model modes
  localparam int MNormal = 0;
  localparam int MSetH   = 1;
  localparam int MSetM   = 2;
  localparam int MRing   = 3;
  localparam int MSnooze = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       en1hz = 1'b0, sig2hz = 1'b0;
  logic [1:0] hour10 = '0;
  logic [3:0] hour1 = '0;
  logic [2:0] min10 = '0;
  logic [3:0] min1 = '0;
  logic [2:0] sec10 = '0;
  logic [3:0] sec1 = '0;
  logic       almset = 1'b0, almadj = 1'b0, almoff = 1'b0;
  logic [1:0] alm_hour10;
  logic [3:0] alm_hour1;
  logic [2:0] alm_min10;
  logic [3:0] alm_min1;
  logic       almdisp, houron, minon, armed, buzz;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: alarm as plain integers, current time as integers.
  int t_h, t_m, t_s;
  int m_mode, m_ah, m_am, m_cnt, m_snz;
  bit m_armed, m_prev;

  alarm_ctrl #(
    .RING_SEC  (RingSec),
    .SNOOZE_SEC(SnoozeSec),
    .SNOOZE_MAX(SnoozeMax)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en1hz     (en1hz),
    .sig2hz    (sig2hz),
    .hour10    (hour10),
    .hour1     (hour1),
    .min10     (min10),
    .min1      (min1),
    .sec10     (sec10),
    .sec1      (sec1),
    .almset    (almset),
    .almadj    (almadj),
    .almoff    (almoff),
    .alm_hour10(alm_hour10),
    .alm_hour1 (alm_hour1),
    .alm_min10 (alm_min10),
    .alm_min1  (alm_min1),
    .almdisp   (almdisp),
    .houron    (houron),
    .minon     (minon),
    .armed     (armed),
    .buzz      (buzz)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = h; t_m = m; t_s = s;
    hour10 = 2'(h / 10); hour1 = 4'(h % 10);
    min10  = 3'(m / 10); min1  = 4'(m % 10);
    sec10  = 3'(s / 10); sec1  = 4'(s % 10);
  endtask

  function automatic bit snooze_allowed();
`ifdef ALARM_SNOOZE_LIMIT_EN
    return m_snz < SnoozeMax;
`else
    return 1'b1;
`endif
  endfunction

  // Advance the model by one clock using the inputs presently applied.
  task automatic model_step();
    bit match, rise;
    int nxt;
    if (!RST) begin
      m_mode = MNormal; m_ah = 0; m_am = 0; m_cnt = 0; m_snz = 0;
      m_armed = 0; m_prev = 0;
      return;
    end
    match  = (t_h == m_ah) && (t_m == m_am) && (t_s == 0);
    rise   = match && !m_prev;
    m_prev = match;
    nxt    = m_mode;
    case (m_mode)
      MNormal: begin
        if (almoff) m_armed = !m_armed;
        else if (almset) nxt = MSetH;
        else if (rise && m_armed) nxt = MRing;
      end
      MSetH: begin
        if (almset) nxt = MSetM;
        else if (almadj) m_ah = (m_ah + 1) % 24;
      end
      MSetM: begin
        if (almset) begin nxt = MNormal; m_armed = 1; end
        else if (almadj) m_am = (m_am + 1) % 60;
      end
      MRing: begin
        if (almoff) nxt = MNormal;
        else if (almadj && snooze_allowed()) begin nxt = MSnooze; m_snz++; end
        else if (en1hz) begin
          m_cnt++;
          if (m_cnt == RingSec) nxt = MNormal;
        end
      end
      default: begin
        if (almoff) nxt = MNormal;
        else if (en1hz) begin
          m_cnt++;
          if (m_cnt == SnoozeSec) nxt = MRing;
        end
      end
    endcase
    if (nxt != m_mode) m_cnt = 0;
    if (nxt == MNormal) m_snz = 0;
    m_mode = nxt;
  endtask

  function automatic logic [17:0] dut_outs();
    return {alm_hour10, alm_hour1, alm_min10, alm_min1, armed, buzz, almdisp, houron, minon};
  endfunction

  function automatic logic [17:0] model_outs();
    logic b, d, ho, mo;
    b  = (m_mode == MRing) && sig2hz;
    d  = (m_mode == MSetH) || (m_mode == MSetM);
    ho = (m_mode != MSetH) || sig2hz;
    mo = (m_mode != MSetM) || sig2hz;
    return {2'(m_ah / 10), 4'(m_ah % 10), 3'(m_am / 10), 4'(m_am % 10), m_armed, b, d, ho, mo};
  endfunction

  // One clock: model and DUT step on the same inputs; outputs compared 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check("model", 32'(dut_outs()), 32'(model_outs()));
    almset = 0; almadj = 0; almoff = 0; en1hz = 0;
  endtask

  task automatic sec_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      en1hz = 1; tick();
      tick();
    end
  endtask

  task automatic trigger(input int h, input int m);
    set_time(h, m + 1, 0); tick();
    set_time(h, m, 0); tick();
  endtask

  initial begin
    logic [12:0] exp_digits;
    set_time(12, 34, 56);
    RST = 0; tick(); tick();
    check("reset_outs", 32'(dut_outs()), 32'h3);
    RST = 1; tick();

    // Set the alarm to 07:30, with blink checks in SETHOUR.
    almset = 1; tick();
    sig2hz = 0; tick();
    check("houron_blink_lo", 32'(houron), 32'd0);
    check("minon_sethour", 32'(minon), 32'd1);
    sig2hz = 1; tick();
    check("houron_blink_hi", 32'(houron), 32'd1);
    for (int i = 0; i < 7; i++) begin almadj = 1; tick(); end
    for (int i = 0; i < 24; i++) begin almadj = 1; tick(); end
    check("hour_wrap", 32'({alm_hour10, alm_hour1}), 32'h07);
    almset = 1; tick();
    for (int i = 0; i < 30; i++) begin almadj = 1; tick(); end
    almset = 1; tick();
    exp_digits = {2'd0, 4'd7, 3'd3, 4'd0};
    check("alarm_0730", 32'({alm_hour10, alm_hour1, alm_min10, alm_min1}), 32'(exp_digits));
    check("armed_after_set", 32'(armed), 32'd1);
    check("almdisp_normal", 32'(almdisp), 32'd0);

    // Ring and auto-stop after 60 seconds; held :00 does not re-trigger.
    set_time(7, 29, 59); tick();
    set_time(7, 30, 0); tick();
    check("ring_start", 32'(buzz), 32'd1);
    sec_pulses(59);
    check("ring_59s", 32'(buzz), 32'd1);
    sec_pulses(1);
    check("ring_autostop", 32'(buzz), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("no_retrigger", 32'(buzz), 32'd0);

    // Snooze, re-ring after 300 s, then stop from snooze.
    trigger(7, 30);
    almadj = 1; tick();
    check("snooze_silent", 32'(buzz), 32'd0);
    sec_pulses(299);
    check("snooze_299s", 32'(buzz), 32'd0);
    sec_pulses(1);
    check("snooze_rering", 32'(buzz), 32'd1);
    almadj = 1; tick();
    almoff = 1; tick();
    check("off_in_snooze_armed", 32'(armed), 32'd1);

    // almoff beats almadj in RING; then disarm and confirm silence.
    trigger(7, 30);
    almoff = 1; almadj = 1; tick();
    check("off_beats_adj", 32'(buzz), 32'd0);
    sec_pulses(5);
    almoff = 1; tick();
    check("disarm", 32'(armed), 32'd0);
    trigger(7, 30);
    check("disarmed_silent", 32'(buzz), 32'd0);

    // Reset in the middle of a ring.
    almoff = 1; tick();
    trigger(7, 30);
    check("ring_before_reset", 32'(buzz), 32'd1);
    RST = 0; tick();
    check("reset_mid_ring", 32'(dut_outs()), 32'h3);
    RST = 1; tick();

    // Snooze limit: alarm is 00:00 after reset.
    almoff = 1; tick();
    trigger(0, 0);
    for (int k = 0; k < 3; k++) begin
      almadj = 1; tick();
      sec_pulses(SnoozeSec);
    end
    almadj = 1; tick();
`ifdef ALARM_SNOOZE_LIMIT_EN
    check("fourth_snooze", 32'(buzz), 32'd1);
`else
    check("fourth_snooze", 32'(buzz), 32'd0);
`endif
    almoff = 1; tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) set_time(m_ah, m_am, 0);
      else if (r == 1) set_time(m_ah, m_am, int'($urandom_range(0, 59)));
      else set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    int'($urandom_range(0, 59)));
      sig2hz = 1'($urandom);
      en1hz  = 1'($urandom);
      almadj = ($urandom_range(0, 7) == 0);
      almset = ($urandom_range(0, 15) == 0);
      almoff = ($urandom_range(0, 31) == 0);
      RST    = !($urandom_range(0, 399) == 0);
      tick();
      RST = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
